usr_sequencer: RTL and testbench

Control FSM that sits directly upstream of the 4-bit universal shift register (USR) in the FSM project. It accepts a one-shot command (op, repeat count, load data), drives the USR select (`si`) and parallel input (`li`) for one load cycle followed by N shift/rotate cycles, and captures the USR output when the sequence completes. The USR output is fed back through `q_fb`, because the USR computes each step from `li`, not from its own register.

---
 rtl/usr_sequencer.sv | 120 ++++++++++++
 tb/tb_usr_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/usr_sequencer.sv
// Command sequencer for the 4-bit universal shift register.
// Issues one load cycle and N op cycles, then captures the USR output from q_fb.
module usr_sequencer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [3:0]       data_in,
  input  logic [3:0]       q_fb,
  output logic [3:0]       li,
  output logic [2:0]       si,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_LOAD = 3'b000;

  logic [1:0]       state_q,  state_d;
  logic [2:0]       op_q,     op_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] rem_q,    rem_d;
  logic [3:0]       data_q,   data_d;
  logic             ill_q,    ill_d;
  logic             done_q,   done_d;
  logic [3:0]       result_q, result_d;
  logic             err_q,    err_d;

  logic op_illegal;

  assign op_illegal = (op == 3'b000) || (op == 3'b100) || (op == 3'b111);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    data_d   = data_q;
    ill_d    = ill_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          cnt_d   = count;
          data_d  = data_in;
          ill_d   = op_illegal;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ill_q || (cnt_q == '0)) begin
          state_d = S_DONE;
        end else begin
          rem_d   = cnt_q;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Saturating decrement; <=1 also exits if remaining were ever 0.
        if (rem_q != '0) rem_d = rem_q - 1'b1;
        if (rem_q <= CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        result_d = q_fb;
        err_d    = ill_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Outside LOAD the USR is fed its own output so it holds between steps.
  always_comb begin
    si = (state_q == S_SHIFT) ? op_q : OP_LOAD;
    li = (state_q == S_LOAD) ? data_q : q_fb;
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Bench for usr_sequencer: a 4-bit USR model closes the q_fb loop, and
// expected results come from an arithmetic reference of the op rules.
module tb_usr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] count;
  logic [3:0] data_in;
  logic [3:0] q_fb;
  logic [3:0] li;
  logic [2:0] si;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  logic [3:0] usr_q = '0;

  int checks = 0;
  int errors = 0;

  usr_sequencer #(.CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .count   (count),
    .data_in (data_in),
    .q_fb    (q_fb),
    .li      (li),
    .si      (si),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  always #5 clk = ~clk;

  // USR: the register always captures f(si, li); it is not on the sequencer reset.
  function automatic logic [3:0] usr_step(input logic [2:0] s, input logic [3:0] v);
    case (s)
      3'b001:  return {v[0], v[3:1]};
      3'b010:  return {v[2:0], v[3]};
      3'b011:  return {1'b0, v[3:1]};
      3'b101:  return {v[3], v[3:1]};
      3'b110:  return {v[2:0], 1'b0};
      default: return v;
    endcase
  endfunction

  always @(posedge clk) usr_q <= usr_step(si, li);
  assign q_fb = usr_q;

  function automatic bit is_illegal(input int o);
    return (o == 0) || (o == 4) || (o == 7);
  endfunction

  function automatic int ref_result(input int o, input int n, input int d);
    int r;
    r = d;
    if (is_illegal(o)) return d;
    for (int i = 0; i < n; i++) begin
      case (o)
        1: r = (r >> 1) | ((r & 1) << 3);
        2: r = ((r << 1) | (r >> 3)) & 15;
        3: r = r >> 1;
        5: r = (r >> 1) | (r & 8);
        6: r = (r << 1) & 15;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and follows it cycle by cycle to the done pulse.
  // pulse=1 strobes start again while busy; it must be ignored.
  task automatic run_cmd(input logic [2:0] o, input logic [2:0] n, input logic [3:0] d,
                         input bit pulse, output logic [3:0] exp_r, output bit exp_e);
    int nsh;
    int lat;
    exp_e = is_illegal(o);
    nsh   = exp_e ? 0 : int'(n);
    lat   = nsh + 3;
    exp_r = 4'(ref_result(o, n, d));
    @(negedge clk);
    start = 1'b1; op = o; count = n; data_in = d;
    @(posedge clk); #1;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k < lat) begin
        check("busy_run", busy, 1);
        check("done_early", done, 0);
        check("si_seq", si, (k >= 2 && k <= nsh + 1) ? o : 3'b000);
        if (k == 1) check("li_load", li, d);
        else        check("li_hold", li, q_fb);
        @(negedge clk);
        start   = pulse && (k == 1);
        op      = 3'($urandom);
        count   = 3'($urandom);
        data_in = 4'($urandom);
      end else begin
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("result", result, exp_r);
        check("err", err, exp_e);
        check("si_idle", si, 0);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input logic [3:0] exp_r, input bit exp_e);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("result_held", result, exp_r);
      check("err_held", err, exp_e);
      check("idle_li", li, q_fb);
    end
  endtask

  initial begin
    logic [3:0] r;
    bit         e;

    reset = 1'b1; start = 1'b0; op = '0; count = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_si", si, 0);
    check("rst_li", li, q_fb);
    @(negedge clk); reset = 1'b0;

    // Directed cases.
    run_cmd(3'b001, 3'd1, 4'b1011, 1'b0, r, e);
    check("ror_value", r, 4'b1101);
    idle_cycles(1, r, e);
    run_cmd(3'b010, 3'd2, 4'b1011, 1'b0, r, e);
    check("rol_value", r, 4'b1110);
    idle_cycles(1, r, e);
    run_cmd(3'b101, 3'd3, 4'b1000, 1'b0, r, e);
    check("asr_value", r, 4'b1111);
    run_cmd(3'b110, 3'd2, 4'b0011, 1'b0, r, e);
    check("lsl_value", r, 4'b1100);
    run_cmd(3'b000, 3'd0, 4'b0101, 1'b0, r, e);
    check("ill0_err", e, 1);
    idle_cycles(2, r, e);
    run_cmd(3'b100, 3'd5, 4'b1010, 1'b1, r, e);
    idle_cycles(4, 4'b1010, 1'b1);
    run_cmd(3'b011, 3'd7, 4'b1111, 1'b1, r, e);
    idle_cycles(1, r, e);

    // Random commands, mixed legal/illegal, busy strobes and back-to-back gaps.
    for (int t = 0; t < 40; t++) begin
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), r, e);
      idle_cycles($urandom_range(0, 2), r, e);
    end

    // Reset in the middle of a long rotate, after a non-zero result exists.
    run_cmd(3'b100, 3'd2, 4'b1010, 1'b0, r, e);
    @(negedge clk);
    start = 1'b1; op = 3'b001; count = 3'd7; data_in = 4'b0110;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_si", si, 3'b001);
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mrst_done", done, 0);
    check("mrst_result", result, 0);
    check("mrst_err", err, 0);
    check("mrst_busy", busy, 0);
    check("mrst_si", si, 0);
    check("mrst_li", li, q_fb);
    @(negedge clk); reset = 1'b0;
    idle_cycles(1, 4'b0000, 1'b0);
    run_cmd(3'b001, 3'd3, 4'b0001, 1'b0, r, e);
    check("post_rst_value", r, 4'b0010);
    idle_cycles(2, r, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
